pulldown_scan_ctrl: RTL and testbench
=====================================

Name: pulldown_scan_ctrl

Overview:
- Sequencer for a bank of pulled-down IO pads: alternates a drive-low discharge phase with a released (hi-Z) settle phase, then samples the pads.
- Debounces each sampled word and reports stable changes to downstream logic through a valid/ready event interface.
- Sits between the pad tristate buffers (drives their low-enable, reads their input) and button/switch consumer logic.

Parameters:
BIT_WIDTH, 8, number of pads controlled.
DRIVE_CYCLES, 4, cycles pads are actively driven low per scan; must be ≥1.
SETTLE_CYCLES, 16, cycles pads are released before sampling; must be ≥3 to cover the 2-flop synchronizer.
DEBOUNCE_SAMPLES, 4, consecutive identical samples required to accept a new value; must be ≥1.

Ports:
clk  input  1  clock.
n_rst  input  1  reset, asynchronous, active-low.
enable  input  1  1 = run scan loop; 0 = park in IDLE.
pad_in  input  BIT_WIDTH  raw pad input values; asynchronous to clk.
pad_drive_low  output  BIT_WIDTH  per-pad enable: 1 = drive pad low, 0 = hi-Z. All bits always equal.
stable  output  BIT_WIDTH  current debounced pad value.
evt_valid  output  1  change event pending.
evt_data  output  BIT_WIDTH  debounced value carried by the pending event.
evt_changed  output  BIT_WIDTH  mask of bits that changed since the last accepted event.
evt_ready  input  1  consumer accepts the event when evt_valid && evt_ready.
overrun  output  1  sticky flag: a change was merged into an unaccepted event.
clear_overrun  input  1  synchronous clear of overrun.

Behaviour:
- Reset (async, n_rst=0): FSM=IDLE, pad_drive_low=all 1s, stable=0, evt_valid=0, evt_data=0, evt_changed=0, overrun=0, synchronizer=0, debounce candidate=0, count=0.
- pad_in passes through a 2-flop synchronizer. The sampled value is the synchronizer output.
- FSM states: IDLE, DRIVE, SETTLE, SAMPLE. One phase counter, sized with $clog2 of the largest phase.
  - IDLE: pad_drive_low=1s. If enable=1, go to DRIVE next cycle.
  - DRIVE: pad_drive_low=1s for exactly DRIVE_CYCLES cycles, then SETTLE.
  - SETTLE: pad_drive_low=0s for exactly SETTLE_CYCLES cycles, then SAMPLE.
  - SAMPLE: pad_drive_low=0s for 1 cycle; capture the synchronized pad value. Next state is DRIVE if enable=1, else IDLE.
- Scan period is DRIVE_CYCLES+SETTLE_CYCLES+1 (21 with defaults).
- enable=0 in DRIVE or SETTLE aborts the scan: next cycle is IDLE, no sample is taken, and debounce state is retained. enable=0 during SAMPLE still completes that sample.
- Debounce, evaluated once per SAMPLE:
  - If sample==candidate: count increments, saturating at DEBOUNCE_SAMPLES.
  - Otherwise: candidate<=sample and count<=1.
  - When the post-update count equals DEBOUNCE_SAMPLES and candidate≠stable: on the following cycle, stable<=candidate and an event is raised with change=candidate^old stable.
- Event handshake:
  - evt_valid stays high until accepted. evt_data and evt_changed hold while valid, except when merging.
  - Accept with no new event: evt_valid<=0 next cycle; evt_changed<=0.
  - New event, with evt_valid=0 or accept in the same cycle: evt_data<=new stable, evt_changed<=change, evt_valid<=1.
  - New event while evt_valid=1 and not accepted (merge): evt_data<=new stable, evt_changed<=evt_changed|change, overrun<=1.
- overrun is sticky. clear_overrun=1 clears it next cycle. A merge in the same cycle as clear_overrun wins (overrun=1).
- stable always tracks accepted debounced values regardless of backpressure.
- Reset mid-scan or mid-handshake: immediate return to the reset values above; any pending event is lost.

Test Plan:
- Reset: n_rst=0 with enable=1, pad_in=8'hFF -> pad_drive_low=8'hFF, evt_valid=0, stable=8'h00, overrun=0 while reset held.
- Timing: enable=1 from IDLE -> pad_drive_low=8'hFF for 4 cycles, then 8'h00 for 17 cycles (16 SETTLE + 1 SAMPLE), repeating with period 21.
- Debounce accept: pad_in=8'h05 held -> after the 4th SAMPLE, stable=8'h05, evt_valid=1, evt_data=8'h05, evt_changed=8'h05; evt_ready=1 -> evt_valid=0 next cycle.
- Glitch reject: pad_in=8'h05 for 3 samples, 8'h00 for 1 sample, then 8'h05 -> no event until 4 more consecutive 8'h05 samples; stable stays 8'h00 throughout.
- Backpressure merge: evt_ready=0, stable 8'h00->8'h05->8'h0C -> evt_data=8'h0C, evt_changed=8'h0D, overrun=1; pulse clear_overrun -> overrun=0, event still pending.
- Abort: drop enable mid-SETTLE with a debounce count of 2 -> next cycle IDLE, pad_drive_low=8'hFF, no sample taken; re-enable with the same input -> event after 2 more samples.

Source files
------------

// File: rtl/pulldown_scan_ctrl.sv
// Pulldown pad scanner: drive-low / release / sample loop with per-word debounce.
// Events appear 1 cycle after the qualifying SAMPLE; backpressure merges events and sets sticky overrun.
module pulldown_scan_ctrl #(
  parameter int BIT_WIDTH        = 8,
  parameter int DRIVE_CYCLES     = 4,
  parameter int SETTLE_CYCLES    = 16,
  parameter int DEBOUNCE_SAMPLES = 4
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 enable,
  input  logic [BIT_WIDTH-1:0] pad_in,
  output logic [BIT_WIDTH-1:0] pad_drive_low,
  output logic [BIT_WIDTH-1:0] stable,
  output logic                 evt_valid,
  output logic [BIT_WIDTH-1:0] evt_data,
  output logic [BIT_WIDTH-1:0] evt_changed,
  input  logic                 evt_ready,
  output logic                 overrun,
  input  logic                 clear_overrun
);

  localparam int MAX_PHASE = (DRIVE_CYCLES > SETTLE_CYCLES) ? DRIVE_CYCLES : SETTLE_CYCLES;
  localparam int PW        = (MAX_PHASE > 1) ? $clog2(MAX_PHASE) : 1;
  localparam int DW        = $clog2(DEBOUNCE_SAMPLES + 1);

  localparam logic [PW-1:0] DRIVE_LAST  = PW'(DRIVE_CYCLES - 1);
  localparam logic [PW-1:0] SETTLE_LAST = PW'(SETTLE_CYCLES - 1);
  localparam logic [DW-1:0] DB_FULL     = DW'(DEBOUNCE_SAMPLES);

  typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, SAMPLE} state_t;

  state_t               state;
  logic [PW-1:0]        phase_cnt;
  logic [BIT_WIDTH-1:0] sync_meta;
  logic [BIT_WIDTH-1:0] sync_q;
  logic [BIT_WIDTH-1:0] cand;
  logic [DW-1:0]        db_cnt;
  logic                 commit;

  logic                 sample_match;
  logic [BIT_WIDTH-1:0] next_cand;
  logic [DW-1:0]        next_cnt;
  logic [BIT_WIDTH-1:0] change;
  logic                 accept;
  logic                 merge;

  always_comb begin
    sample_match = (sync_q == cand);
    next_cand    = sample_match ? cand : sync_q;
    next_cnt     = DW'(1);
    if (sample_match) begin
      next_cnt = (db_cnt == DB_FULL) ? db_cnt : db_cnt + DW'(1);
    end
    change = cand ^ stable;
    accept = evt_valid & evt_ready;
    merge  = commit & evt_valid & ~evt_ready;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= pad_in;
      sync_q    <= sync_meta;
    end
  end

  // pad_drive_low is registered from the next state so it changes with the state itself.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      phase_cnt     <= '0;
      pad_drive_low <= '1;
    end else begin
      case (state)
        IDLE: begin
          phase_cnt     <= '0;
          pad_drive_low <= '1;
          if (enable) state <= DRIVE;
        end
        DRIVE: begin
          if (!enable) begin
            state         <= IDLE;
            phase_cnt     <= '0;
            pad_drive_low <= '1;
          end else if (phase_cnt == DRIVE_LAST) begin
            state         <= SETTLE;
            phase_cnt     <= '0;
            pad_drive_low <= '0;
          end else begin
            phase_cnt     <= phase_cnt + PW'(1);
            pad_drive_low <= '1;
          end
        end
        SETTLE: begin
          if (!enable) begin
            state         <= IDLE;
            phase_cnt     <= '0;
            pad_drive_low <= '1;
          end else if (phase_cnt == SETTLE_LAST) begin
            state         <= SAMPLE;
            phase_cnt     <= '0;
            pad_drive_low <= '0;
          end else begin
            phase_cnt     <= phase_cnt + PW'(1);
            pad_drive_low <= '0;
          end
        end
        default: begin
          state         <= enable ? DRIVE : IDLE;
          phase_cnt     <= '0;
          pad_drive_low <= '1;
        end
      endcase
    end
  end

  // Commit is flagged in SAMPLE and applied the following cycle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cand   <= '0;
      db_cnt <= '0;
      commit <= 1'b0;
      stable <= '0;
    end else begin
      commit <= (state == SAMPLE) && (next_cnt == DB_FULL) && (next_cand != stable);
      if (state == SAMPLE) begin
        cand   <= next_cand;
        db_cnt <= next_cnt;
      end
      if (commit) stable <= cand;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      evt_valid   <= 1'b0;
      evt_data    <= '0;
      evt_changed <= '0;
      overrun     <= 1'b0;
    end else begin
      if (commit) begin
        evt_valid   <= 1'b1;
        evt_data    <= cand;
        evt_changed <= merge ? (evt_changed | change) : change;
      end else if (accept) begin
        evt_valid   <= 1'b0;
        evt_changed <= '0;
      end
      if (merge) overrun <= 1'b1;
      else if (clear_overrun) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pulldown_scan_ctrl.sv
// Bench for pulldown_scan_ctrl: scan timing, debounce, handshake, merge and abort scenarios.
module tb_pulldown_scan_ctrl;

  localparam int N      = 4;
  localparam int PERIOD = 21;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       enable;
  logic [7:0] pad_in;
  logic [7:0] pad_drive_low;
  logic [7:0] stable;
  logic       evt_valid;
  logic [7:0] evt_data;
  logic [7:0] evt_changed;
  logic       evt_ready;
  logic       overrun;
  logic       clear_overrun;

  always #5 clk = ~clk;

  pulldown_scan_ctrl dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .enable       (enable),
    .pad_in       (pad_in),
    .pad_drive_low(pad_drive_low),
    .stable       (stable),
    .evt_valid    (evt_valid),
    .evt_data     (evt_data),
    .evt_changed  (evt_changed),
    .evt_ready    (evt_ready),
    .overrun      (overrun),
    .clear_overrun(clear_overrun)
  );

  typedef struct packed {
    logic [7:0] d;
    logic [7:0] c;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        mon_e;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] m_cand;
  logic [7:0] m_stable;
  int         m_cnt;
  bit         m_overrun;

  // Pops one expected event per accepted handshake.
  always @(negedge clk) begin
    if (n_rst === 1'b1 && evt_valid === 1'b1 && evt_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL evt_unexpected: got data=%h changed=%h, no event expected", evt_data, evt_changed);
      end else begin
        mon_e = exp_q.pop_front();
        if (evt_data !== mon_e.d || evt_changed !== mon_e.c) begin
          errors++;
          $display("FAIL evt_accept: got data=%h changed=%h expected data=%h changed=%h",
                   evt_data, evt_changed, mon_e.d, mon_e.c);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic do_reset();
    n_rst = 1'b0;
    enable = 1'b0;
    evt_ready = 1'b0;
    clear_overrun = 1'b0;
    pad_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    exp_q.delete();
    m_cand = 8'h00;
    m_stable = 8'h00;
    m_cnt = 0;
    m_overrun = 1'b0;
  endtask

  task automatic start_scan();
    enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // One full scan with pad value v; model updated at the point the DUT's event becomes visible.
  task automatic do_scan(input logic [7:0] v, output bit fired);
    logic [7:0] chg;
    ev_t        e;
    pad_in = v;
    repeat (PERIOD) @(posedge clk);
    #1;
    if (v == m_cand) begin
      if (m_cnt < N) m_cnt++;
    end else begin
      m_cand = v;
      m_cnt = 1;
    end
    fired = 1'b0;
    if (m_cnt == N && m_cand != m_stable) begin
      chg = m_cand ^ m_stable;
      m_stable = m_cand;
      fired = 1'b1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_back();
        e.d = m_stable;
        e.c = e.c | chg;
        m_overrun = 1'b1;
      end else begin
        e.d = m_stable;
        e.c = chg;
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    enable = 1'b1;
    pad_in = 8'hFF;
    evt_ready = 1'b0;
    clear_overrun = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (pad_drive_low !== 8'hFF) begin errors++; $display("FAIL reset_pdl: got %h expected ff", pad_drive_low); end
    checks++;
    if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", evt_valid); end
    checks++;
    if (stable !== 8'h00) begin errors++; $display("FAIL reset_stable: got %h expected 00", stable); end
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    checks++;
    if (evt_data !== 8'h00 || evt_changed !== 8'h00) begin
      errors++; $display("FAIL reset_evt: got data=%h changed=%h expected 00/00", evt_data, evt_changed);
    end
  endtask

  task automatic test_timing();
    logic [7:0] exp;
    pad_in = 8'h00;
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    for (int i = 0; i < 2 * PERIOD; i++) begin
      @(posedge clk);
      #1;
      exp = ((i % PERIOD) < 4) ? 8'hFF : 8'h00;
      checks++;
      if (pad_drive_low !== exp) begin
        errors++;
        $display("FAIL timing_pdl[%0d]: got %h expected %h", i, pad_drive_low, exp);
      end
    end
  endtask

  task automatic test_debounce_accept();
    bit fired;
    do_reset();
    evt_ready = 1'b1;
    start_scan();
    for (int s = 0; s < 4; s++) begin
      do_scan(8'h05, fired);
      checks++;
      if (evt_valid !== (s == 3) || stable !== m_stable) begin
        errors++;
        $display("FAIL accept_scan[%0d]: got valid=%b stable=%h expected valid=%b stable=%h",
                 s, evt_valid, stable, (s == 3), m_stable);
      end
    end
    checks++;
    if (stable !== 8'h05 || evt_data !== 8'h05 || evt_changed !== 8'h05) begin
      errors++;
      $display("FAIL accept_evt: got stable=%h data=%h changed=%h expected 05/05/05", stable, evt_data, evt_changed);
    end
    @(posedge clk);
    #1;
    checks++;
    if (evt_valid !== 1'b0 || evt_changed !== 8'h00) begin
      errors++;
      $display("FAIL accept_clear: got valid=%b changed=%h expected 0/00", evt_valid, evt_changed);
    end
  endtask

  task automatic test_glitch();
    logic [7:0] pat [8];
    bit fired;
    pat = '{8'h05, 8'h05, 8'h05, 8'h00, 8'h05, 8'h05, 8'h05, 8'h05};
    do_reset();
    evt_ready = 1'b1;
    start_scan();
    for (int k = 0; k < 8; k++) begin
      do_scan(pat[k], fired);
      checks++;
      if (evt_valid !== (k == 7) || stable !== ((k == 7) ? 8'h05 : 8'h00)) begin
        errors++;
        $display("FAIL glitch_scan[%0d]: got valid=%b stable=%h expected valid=%b stable=%h",
                 k, evt_valid, stable, (k == 7), ((k == 7) ? 8'h05 : 8'h00));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    bit fired;
    do_reset();
    evt_ready = 1'b0;
    start_scan();
    for (int s = 0; s < 4; s++) do_scan(8'h05, fired);
    checks++;
    if (evt_valid !== 1'b1 || overrun !== 1'b0 || evt_data !== 8'h05) begin
      errors++;
      $display("FAIL bp_first: got valid=%b overrun=%b data=%h expected 1/0/05", evt_valid, overrun, evt_data);
    end
    for (int s = 0; s < 4; s++) do_scan(8'h0C, fired);
    checks++;
    if (evt_data !== 8'h0C || evt_changed !== 8'h0D || evt_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_merge: got valid=%b data=%h changed=%h expected 1/0c/0d", evt_valid, evt_data, evt_changed);
    end
    checks++;
    if (overrun !== m_overrun || stable !== 8'h0C) begin
      errors++;
      $display("FAIL bp_overrun: got overrun=%b stable=%h expected %b/0c", overrun, stable, m_overrun);
    end
    clear_overrun = 1'b1;
    @(posedge clk);
    #1;
    clear_overrun = 1'b0;
    checks++;
    if (overrun !== 1'b0 || evt_valid !== 1'b1 || evt_data !== 8'h0C) begin
      errors++;
      $display("FAIL bp_clear: got overrun=%b valid=%b data=%h expected 0/1/0c", overrun, evt_valid, evt_data);
    end
    evt_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (evt_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got valid=%b expected 0", evt_valid); end
  endtask

  task automatic test_abort();
    bit fired;
    do_reset();
    evt_ready = 1'b1;
    start_scan();
    do_scan(8'h05, fired);
    do_scan(8'h05, fired);
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (pad_drive_low !== 8'h00) begin errors++; $display("FAIL abort_settle: got %h expected 00", pad_drive_low); end
    enable = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (pad_drive_low !== 8'hFF) begin errors++; $display("FAIL abort_idle: got %h expected ff", pad_drive_low); end
    repeat (15) @(posedge clk);
    #1;
    checks++;
    if (evt_valid !== 1'b0 || stable !== 8'h00) begin
      errors++; $display("FAIL abort_hold: got valid=%b stable=%h expected 0/00", evt_valid, stable);
    end
    start_scan();
    do_scan(8'h05, fired);
    checks++;
    if (evt_valid !== 1'b0) begin errors++; $display("FAIL abort_resume1: got valid=%b expected 0", evt_valid); end
    do_scan(8'h05, fired);
    checks++;
    if (evt_valid !== 1'b1 || stable !== 8'h05 || evt_data !== 8'h05) begin
      errors++;
      $display("FAIL abort_resume2: got valid=%b stable=%h data=%h expected 1/05/05", evt_valid, stable, evt_data);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_timing();
    test_debounce_accept();
    test_glitch();
    test_backpressure();
    test_abort();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d events outstanding expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
